// File: rtl/gmii_rx_pkg.sv
// Shared definitions for the GMII receive MAC with destination-IP filtering.
// Holds the receive FSM state type, the status error codes, the protocol
// constants and the byte-wise CRC-32 step used by crc32_d8.
package gmii_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PREAMBLE  = 3'd1,
        ST_HDR_MAC   = 3'd2,
        ST_ETYPE     = 3'd3,
        ST_VLAN      = 3'd4,
        ST_PAYLOAD   = 3'd5,
        ST_DROP      = 3'd6,
        ST_WAIT_IDLE = 3'd7
    } rx_state_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_RXER     = 3'd1;
    localparam logic [2:0] ERR_LEN      = 3'd2;
    localparam logic [2:0] ERR_OVERSIZE = 3'd3;
    localparam logic [2:0] ERR_CRC      = 3'd4;
    localparam logic [2:0] ERR_VLAN     = 3'd5;
    localparam logic [2:0] ERR_MAC      = 3'd6;
    localparam logic [2:0] ERR_PREAMBLE = 3'd7;

    localparam logic [15:0] ETH_IPV4 = 16'h0800;
    localparam logic [15:0] ETH_VLAN = 16'h8100;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;

    localparam logic [10:0] MIN_FRAME = 11'd64;
    localparam logic [10:0] MAX_FRAME = 11'd1518;

    // Reflected CRC-32 advanced by one byte, data LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ (((c[0] ^ d[i]) == 1'b1) ? CRC_POLY : 32'h0000_0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational one-byte CRC-32 step (Ethernet FCS polynomial, reflected).
// Ports: crc_in - current CRC register, d - received byte, crc_out - updated CRC.
module crc32_d8
    import gmii_rx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    assign crc_out = crc32_byte(crc_in, d);

endmodule

// File: rtl/gmii_rx_ip_filter.sv
// GMII receive MAC with IPv4 destination filtering.
// Inputs : rx_clk, reset_n (async active-low), rxd/rxdv/rxer from the PHY.
// Outputs: out_data/out_valid/out_sof/out_eof - frame bytes DA..FCS delayed
//          by two cycles; frame_done pulse with frame_good, crc_ok, ip_match,
//          ip_match_idx and err_code held until the next frame_done.
module gmii_rx_ip_filter
    import gmii_rx_pkg::*;
#(
    parameter int                 N_IP          = 5,
    parameter logic [N_IP*32-1:0] IP_TABLE      = {32'hC0A8_0005, 32'hC0A8_0166, 32'hC0A8_0003,
                                                   32'hC0A8_0002, 32'hC0A8_0001},
    parameter logic [47:0]        MAC_ADDR      = 48'h386b_1c1d_f565,
    parameter bit                 MAC_FILTER_EN = 1'b0,
    parameter int                 MAX_VLAN      = 2,
    parameter int                 MIN_PREAMBLE  = 7,
    localparam int                IDX_W         = (N_IP > 1) ? $clog2(N_IP) : 1
)(
    input  logic             rx_clk,
    input  logic             reset_n,
    input  logic [7:0]       rxd,
    input  logic             rxdv,
    input  logic             rxer,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eof,
    output logic             frame_done,
    output logic             frame_good,
    output logic             crc_ok,
    output logic             ip_match,
    output logic [IDX_W-1:0] ip_match_idx,
    output logic [2:0]       err_code
);

    rx_state_t        state_r, state_s;
    logic [3:0]       pre_cnt_r, pre_cnt_s;
    logic [3:0]       hdr_cnt_r, hdr_cnt_s;
    logic [2:0]       vlan_cnt_r, vlan_cnt_s;
    logic [4:0]       pay_cnt_r, pay_cnt_s;
    logic [10:0]      byte_cnt_r, byte_cnt_s;
    logic [7:0]       etype_hi_r, etype_hi_s;
    logic             ipv4_r, ipv4_s;
    logic [31:0]      ip_dst_r, ip_dst_s;
    logic             ip_hit_r, ip_hit_s;
    logic [IDX_W-1:0] ip_idx_r, ip_idx_s;
    logic [47:0]      da_r, da_s;
    logic [31:0]      crc_r, crc_s, crc_step_s;
    logic [2:0]       drop_err_r, drop_err_s;
    logic             in_frame_r, in_frame_s;
    logic [7:0]       d1_r;
    logic             v1_r, sof1_r;
    logic [7:0]       out_data_r;
    logic             out_valid_r, out_sof_r, out_eof_r;
    logic             done_r, done_s;
    logic             good_r, good_s, crc_ok_r, crc_ok_s, ip_match_r, ip_match_s;
    logic [IDX_W-1:0] match_idx_r, match_idx_s;
    logic [2:0]       err_r, err_s, fin_err_s, end_err_s;
    logic             frame_byte_s, da_ok_s;
    logic [31:0]      ip_shift_s;
    logic [IDX_W:0]   lookup_s;
    logic [10:0]      len_max_s;

    // Returns {hit, index}; scanning downward lets the lowest index win.
    function automatic logic [IDX_W:0] ip_lookup(input logic [31:0] ip);
        logic [IDX_W:0] res;
        res = {(IDX_W+1){1'b0}};
        for (int i = N_IP - 1; i >= 0; i--) begin
            if (IP_TABLE[32*i +: 32] == ip) res = {1'b1, IDX_W'(i)};
        end
        return res;
    endfunction

    crc32_d8 u_crc (
        .crc_in  (crc_r),
        .d       (rxd),
        .crc_out (crc_step_s)
    );

    assign frame_byte_s = rxdv && in_frame_r;
    assign ip_shift_s   = {ip_dst_r[23:0], rxd};
    assign lookup_s     = ip_lookup(ip_shift_s);
    assign da_ok_s      = (da_r == MAC_ADDR) || (da_r == 48'hFFFF_FFFF_FFFF);
    assign len_max_s    = MAX_FRAME + {6'd0, vlan_cnt_r, 2'b00};

    // Verdict for a frame that reached PAYLOAD and ended normally.
    always_comb begin
        if (byte_cnt_r < MIN_FRAME)                 end_err_s = ERR_LEN;
        else if (byte_cnt_r > len_max_s)            end_err_s = ERR_OVERSIZE;
        else if (crc_r != CRC_RESIDUE)              end_err_s = ERR_CRC;
        else if (MAC_FILTER_EN && !da_ok_s)         end_err_s = ERR_MAC;
        else                                        end_err_s = ERR_NONE;
    end

    // Receive FSM next-state and per-frame bookkeeping.
    always_comb begin
        state_s    = state_r;
        pre_cnt_s  = pre_cnt_r;
        hdr_cnt_s  = hdr_cnt_r;
        vlan_cnt_s = vlan_cnt_r;
        pay_cnt_s  = pay_cnt_r;
        etype_hi_s = etype_hi_r;
        ipv4_s     = ipv4_r;
        ip_dst_s   = ip_dst_r;
        ip_hit_s   = ip_hit_r;
        ip_idx_s   = ip_idx_r;
        da_s       = da_r;
        drop_err_s = drop_err_r;
        done_s     = 1'b0;
        fin_err_s  = ERR_NONE;
        in_frame_s = rxdv ? in_frame_r : 1'b0;
        crc_s      = frame_byte_s ? crc_step_s : crc_r;
        byte_cnt_s = (frame_byte_s && (byte_cnt_r != 11'h7FF)) ? byte_cnt_r + 11'd1 : byte_cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (rxdv && (rxd == PREAMBLE_BYTE)) begin
                    // Per-frame state is cleared here so a frame dropped in
                    // the preamble never reports a stale CRC or IP match.
                    state_s    = ST_PREAMBLE;
                    pre_cnt_s  = 4'd1;
                    crc_s      = CRC_INIT;
                    byte_cnt_s = 11'd0;
                    vlan_cnt_s = 3'd0;
                    ipv4_s     = 1'b0;
                    ip_hit_s   = 1'b0;
                    ip_idx_s   = {IDX_W{1'b0}};
                    da_s       = 48'd0;
                    drop_err_s = ERR_NONE;
                end else if (rxdv) begin
                    state_s = ST_WAIT_IDLE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (!rxdv) begin
                    state_s = ST_IDLE;
                end else if (rxer) begin
                    state_s    = ST_DROP;
                    drop_err_s = ERR_RXER;
                end else if (rxd == PREAMBLE_BYTE) begin
                    pre_cnt_s = (pre_cnt_r == 4'd15) ? pre_cnt_r : pre_cnt_r + 4'd1;
                end else if ((rxd == SFD_BYTE) && (pre_cnt_r >= 4'(MIN_PREAMBLE))) begin
                    state_s    = ST_HDR_MAC;
                    in_frame_s = 1'b1;
                    hdr_cnt_s  = 4'd0;
                end else begin
                    state_s    = ST_DROP;
                    drop_err_s = ERR_PREAMBLE;
                end
            end
            ST_HDR_MAC, ST_ETYPE, ST_VLAN: begin
                if (!rxdv) begin
                    state_s   = ST_IDLE;
                    done_s    = 1'b1;
                    fin_err_s = ERR_LEN;
                end else if (rxer) begin
                    state_s    = ST_DROP;
                    drop_err_s = ERR_RXER;
                end else if (state_r == ST_HDR_MAC) begin
                    da_s      = (hdr_cnt_r < 4'd6) ? {da_r[39:0], rxd} : da_r;
                    state_s   = (hdr_cnt_r == 4'd11) ? ST_ETYPE : ST_HDR_MAC;
                    hdr_cnt_s = (hdr_cnt_r == 4'd11) ? 4'd0 : hdr_cnt_r + 4'd1;
                end else if (state_r == ST_VLAN) begin
                    state_s   = (hdr_cnt_r == 4'd1) ? ST_ETYPE : ST_VLAN;
                    hdr_cnt_s = (hdr_cnt_r == 4'd1) ? 4'd0 : 4'd1;
                end else if (hdr_cnt_r == 4'd0) begin
                    etype_hi_s = rxd;
                    hdr_cnt_s  = 4'd1;
                end else begin
                    hdr_cnt_s = 4'd0;
                    if ({etype_hi_r, rxd} != ETH_VLAN) begin
                        state_s   = ST_PAYLOAD;
                        ipv4_s    = ({etype_hi_r, rxd} == ETH_IPV4);
                        pay_cnt_s = 5'd0;
                    end else if (vlan_cnt_r >= 3'(MAX_VLAN)) begin
                        state_s    = ST_DROP;
                        drop_err_s = ERR_VLAN;
                    end else begin
                        state_s    = ST_VLAN;
                        vlan_cnt_s = vlan_cnt_r + 3'd1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (!rxdv) begin
                    state_s   = ST_IDLE;
                    done_s    = 1'b1;
                    fin_err_s = end_err_s;
                end else if (rxer) begin
                    state_s    = ST_DROP;
                    drop_err_s = ERR_RXER;
                end else begin
                    // IPv4 destination sits at payload offsets 16..19.
                    pay_cnt_s = (pay_cnt_r == 5'd31) ? pay_cnt_r : pay_cnt_r + 5'd1;
                    ip_dst_s  = (ipv4_r && (pay_cnt_r >= 5'd16) && (pay_cnt_r <= 5'd19)) ? ip_shift_s : ip_dst_r;
                    ip_hit_s  = (ipv4_r && (pay_cnt_r == 5'd19)) ? lookup_s[IDX_W] : ip_hit_r;
                    ip_idx_s  = (ipv4_r && (pay_cnt_r == 5'd19)) ? lookup_s[IDX_W-1:0] : ip_idx_r;
                end
            end
            ST_DROP: begin
                if (!rxdv) begin
                    state_s   = ST_IDLE;
                    done_s    = 1'b1;
                    fin_err_s = drop_err_r;
                end else if (rxer) begin
                    drop_err_s = ERR_RXER;
                end else begin
                    drop_err_s = drop_err_r;
                end
            end
            ST_WAIT_IDLE: begin
                state_s = rxdv ? ST_WAIT_IDLE : ST_IDLE;
            end
            default: begin
                state_s = ST_WAIT_IDLE;
            end
        endcase
    end

    // Status record captured on frame completion, otherwise held.
    always_comb begin
        err_s       = done_s ? fin_err_s : err_r;
        crc_ok_s    = done_s ? (crc_r == CRC_RESIDUE) : crc_ok_r;
        ip_match_s  = done_s ? ip_hit_r : ip_match_r;
        match_idx_s = done_s ? ip_idx_r : match_idx_r;
        good_s      = done_s ? ((fin_err_s == ERR_NONE) && ip_hit_r) : good_r;
    end

    // State, counters, two-stage data path and status registers.
    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_WAIT_IDLE;
            pre_cnt_r   <= 4'd0;
            hdr_cnt_r   <= 4'd0;
            vlan_cnt_r  <= 3'd0;
            pay_cnt_r   <= 5'd0;
            byte_cnt_r  <= 11'd0;
            etype_hi_r  <= 8'd0;
            ipv4_r      <= 1'b0;
            ip_dst_r    <= 32'd0;
            ip_hit_r    <= 1'b0;
            ip_idx_r    <= {IDX_W{1'b0}};
            da_r        <= 48'd0;
            crc_r       <= CRC_INIT;
            drop_err_r  <= ERR_NONE;
            in_frame_r  <= 1'b0;
            d1_r        <= 8'd0;
            v1_r        <= 1'b0;
            sof1_r      <= 1'b0;
            out_data_r  <= 8'd0;
            out_valid_r <= 1'b0;
            out_sof_r   <= 1'b0;
            out_eof_r   <= 1'b0;
            done_r      <= 1'b0;
            good_r      <= 1'b0;
            crc_ok_r    <= 1'b0;
            ip_match_r  <= 1'b0;
            match_idx_r <= {IDX_W{1'b0}};
            err_r       <= ERR_NONE;
        end else begin
            state_r     <= state_s;
            pre_cnt_r   <= pre_cnt_s;
            hdr_cnt_r   <= hdr_cnt_s;
            vlan_cnt_r  <= vlan_cnt_s;
            pay_cnt_r   <= pay_cnt_s;
            byte_cnt_r  <= byte_cnt_s;
            etype_hi_r  <= etype_hi_s;
            ipv4_r      <= ipv4_s;
            ip_dst_r    <= ip_dst_s;
            ip_hit_r    <= ip_hit_s;
            ip_idx_r    <= ip_idx_s;
            da_r        <= da_s;
            crc_r       <= crc_s;
            drop_err_r  <= drop_err_s;
            in_frame_r  <= in_frame_s;
            d1_r        <= rxd;
            v1_r        <= frame_byte_s;
            sof1_r      <= frame_byte_s && (byte_cnt_r == 11'd0);
            out_data_r  <= d1_r;
            out_valid_r <= v1_r;
            out_sof_r   <= sof1_r;
            // The byte in stage 1 is the last one if rxdv has just dropped.
            out_eof_r   <= v1_r && !rxdv;
            done_r      <= done_s;
            good_r      <= good_s;
            crc_ok_r    <= crc_ok_s;
            ip_match_r  <= ip_match_s;
            match_idx_r <= match_idx_s;
            err_r       <= err_s;
        end
    end

    assign out_data     = out_data_r;
    assign out_valid    = out_valid_r;
    assign out_sof      = out_sof_r;
    assign out_eof      = out_eof_r;
    assign frame_done   = done_r;
    assign frame_good   = good_r;
    assign crc_ok       = crc_ok_r;
    assign ip_match     = ip_match_r;
    assign ip_match_idx = match_idx_r;
    assign err_code     = err_r;

endmodule

// File: tb/tb_gmii_rx_ip_filter.sv
// Directed scoreboard bench for gmii_rx_ip_filter: frames are built with a
// software FCS, expected bytes and status records are queued as stimulus is
// driven, and a monitor pops and checks them when the DUT produces output.
module tb_gmii_rx_ip_filter;

    logic       rx_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rxd = 8'h00;
    logic       rxdv = 1'b0;
    logic       rxer = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, out_sof, out_eof;
    logic       frame_done, frame_good, crc_ok, ip_match;
    logic [2:0] ip_match_idx;
    logic [2:0] err_code;

    gmii_rx_ip_filter dut (
        .rx_clk       (rx_clk),
        .reset_n      (reset_n),
        .rxd          (rxd),
        .rxdv         (rxdv),
        .rxer         (rxer),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_sof      (out_sof),
        .out_eof      (out_eof),
        .frame_done   (frame_done),
        .frame_good   (frame_good),
        .crc_ok       (crc_ok),
        .ip_match     (ip_match),
        .ip_match_idx (ip_match_idx),
        .err_code     (err_code)
    );

    always #5 rx_clk = ~rx_clk;

    typedef struct {
        logic [2:0] err;
        logic       good;
        bit         chk_crc;
        logic       crc;
        bit         chk_ip;
        logic       ipm;
        logic [2:0] idx;
        int         nbytes;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] byte_q[$];
    logic [7:0] frm[$];
    logic [47:0] mac = 48'h386b_1c1d_f565;
    int total = 0;
    int bad = 0;
    int n_exp = 0;
    int n_done = 0;
    int cyc = 0;
    int sof_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int b = 0; b < 8; b++) begin
            if ((c[0] ^ d[b]) == 1'b1) c = (c >> 1) ^ 32'hEDB8_8320;
            else c = c >> 1;
        end
        return c;
    endfunction

    // IPv4/UDP frame: DA=local MAC, optional VLAN tags, 20-byte IP header, pad, FCS.
    task automatic build_frame(input logic [31:0] dst, input int tags, input int total_len);
        logic [31:0] c;
        logic [15:0] iplen;
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(mac[47-8*i -: 8]);
        frm.push_back(8'h02); frm.push_back(8'h11); frm.push_back(8'h22);
        frm.push_back(8'h33); frm.push_back(8'h44); frm.push_back(8'h55);
        for (int t = 0; t < tags; t++) begin
            frm.push_back(8'h81); frm.push_back(8'h00);
            frm.push_back(8'h00); frm.push_back(8'(t + 1));
        end
        frm.push_back(8'h08); frm.push_back(8'h00);
        iplen = 16'(total_len - 18 - 4 * tags);
        frm.push_back(8'h45); frm.push_back(8'h00); frm.push_back(iplen[15:8]); frm.push_back(iplen[7:0]);
        frm.push_back(8'h00); frm.push_back(8'h01); frm.push_back(8'h00); frm.push_back(8'h00);
        frm.push_back(8'h40); frm.push_back(8'h11); frm.push_back(8'h00); frm.push_back(8'h00);
        frm.push_back(8'hC0); frm.push_back(8'hA8); frm.push_back(8'h00); frm.push_back(8'h0A);
        frm.push_back(dst[31:24]); frm.push_back(dst[23:16]); frm.push_back(dst[15:8]); frm.push_back(dst[7:0]);
        while (frm.size() < total_len - 4) frm.push_back(8'(frm.size() * 7));
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < frm.size(); i++) c = crc_upd(c, frm[i]);
        c = ~c;
        frm.push_back(c[7:0]); frm.push_back(c[15:8]); frm.push_back(c[23:16]); frm.push_back(c[31:24]);
    endtask

    task automatic drive(input logic dv, input logic [7:0] d, input logic er);
        @(negedge rx_clk);
        rxdv = dv;
        rxd  = d;
        rxer = er;
    endtask

    task automatic push_exp(input logic [2:0] err, input logic good, input bit chk_crc, input logic crc,
                            input bit chk_ip, input logic ipm, input logic [2:0] idx, input int nbytes);
        exp_t e;
        e.err = err; e.good = good; e.chk_crc = chk_crc; e.crc = crc;
        e.chk_ip = chk_ip; e.ipm = ipm; e.idx = idx; e.nbytes = nbytes;
        exp_q.push_back(e);
        n_exp++;
    endtask

    // Preamble, SFD, the frame in frm, then a single idle cycle.
    task automatic send_frame(input int npre, input int rxer_at, input bit push_out);
        for (int i = 0; i < npre; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < frm.size(); i++) begin
            drive(1'b1, frm[i], (i == rxer_at));
            if (push_out) byte_q.push_back(frm[i]);
        end
        drive(1'b0, 8'h00, 1'b0);
    endtask

    // Output monitor: byte stream and status records against the scoreboard.
    initial begin
        exp_t e;
        logic [7:0] b;
        forever begin
            @(negedge rx_clk);
            cyc++;
            if (out_valid) begin
                if (byte_q.size() == 0) check("out_valid_extra", 32'(out_valid), 32'd0);
                else begin
                    b = byte_q.pop_front();
                    check("out_data", 32'(out_data), 32'(b));
                end
            end
            if (out_sof) sof_cyc = cyc;
            if (out_eof && !frame_done) check("eof_without_done", 32'(frame_done), 32'd1);
            if (frame_done) begin
                n_done++;
                if (exp_q.size() == 0) check("unexpected_done", 32'(frame_done), 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("err_code", 32'(err_code), 32'(e.err));
                    check("frame_good", 32'(frame_good), 32'(e.good));
                    if (e.chk_crc) check("crc_ok", 32'(crc_ok), 32'(e.crc));
                    if (e.chk_ip) begin
                        check("ip_match", 32'(ip_match), 32'(e.ipm));
                        if (e.ipm) check("ip_match_idx", 32'(ip_match_idx), 32'(e.idx));
                    end
                    if (e.nbytes > 0) begin
                        check("eof_with_done", 32'(out_eof), 32'd1);
                        check("sof_eof_gap", 32'(cyc - sof_cyc), 32'(e.nbytes - 1));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, during and just after reset.
        repeat (3) @(negedge rx_clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_status", {24'd0, frame_good, crc_ok, ip_match, ip_match_idx, err_code}, 32'd0);
        reset_n = 1'b1;
        @(negedge rx_clk);
        check("rst_out_sof_eof", {30'd0, out_sof, out_eof}, 32'd0);

        // Good 64-byte frame to 192.168.1.102 (entry 3).
        build_frame(32'hC0A8_0166, 0, 64);
        push_exp(3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 64);
        send_frame(7, -1, 1'b1);

        // Same frame with an FCS bit flipped.
        frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h10;
        push_exp(3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 64);
        send_frame(7, -1, 1'b1);

        // Two VLAN tags, destination not in table.
        build_frame(32'h0A00_0001, 2, 72);
        push_exp(3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 72);
        send_frame(7, -1, 1'b1);

        // Three VLAN tags exceed the limit.
        build_frame(32'hC0A8_0166, 3, 76);
        push_exp(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 76);
        send_frame(7, -1, 1'b1);

        // rxer at frame byte 30.
        build_frame(32'hC0A8_0166, 0, 64);
        push_exp(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 64);
        send_frame(7, 30, 1'b1);

        // Runts: 40 bytes and 63 bytes, both with good FCS.
        build_frame(32'hC0A8_0166, 0, 40);
        push_exp(3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 40);
        send_frame(7, -1, 1'b1);
        build_frame(32'hC0A8_0002, 0, 63);
        push_exp(3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 63);
        send_frame(7, -1, 1'b1);

        // Largest legal untagged frame, then an oversize one.
        build_frame(32'hC0A8_0003, 0, 1518);
        push_exp(3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 1518);
        send_frame(7, -1, 1'b1);
        build_frame(32'hC0A8_0001, 0, 1600);
        push_exp(3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1600);
        send_frame(7, -1, 1'b1);

        // Reset for two cycles mid-payload: that frame must vanish.
        build_frame(32'hC0A8_0005, 0, 64);
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, frm[i], 1'b0);
            byte_q.push_back(frm[i]);
        end
        #2;
        reset_n = 1'b0;
        byte_q.delete();
        drive(1'b1, frm[30], 1'b0);
        drive(1'b1, frm[31], 1'b0);
        #2;
        reset_n = 1'b1;
        for (int i = 32; i < frm.size(); i++) drive(1'b1, frm[i], 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        push_exp(3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 64);
        send_frame(7, -1, 1'b1);

        // Short preamble: dropped with err 7, no bytes forwarded.
        build_frame(32'hC0A8_0166, 0, 64);
        push_exp(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0);
        send_frame(3, -1, 1'b0);

        // Preamble aborted by rxdv low: silent; then a good frame back-to-back.
        for (int i = 0; i < 4; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        build_frame(32'hC0A8_0002, 0, 64);
        push_exp(3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 64);
        send_frame(7, -1, 1'b1);

        repeat (10) drive(1'b0, 8'h00, 1'b0);
        check("frames_done", 32'(n_done), 32'(n_exp));
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("byte_q_empty", 32'(byte_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
